lsu_rmw: RTL

- Load/store unit between the MEM-stage pipeline register and the word-only data memory (12-bit byte address, 32-bit word write, combinational read).
- Handles RV32I sub-word stores (SB/SH) by read-modify-write, since the memory only does full-word writes.
- Produces sign- or zero-extended load data (LB/LH/LW/LBU/LHU).
- Stalls the pipeline for one cycle per sub-word store.

---
 rtl/lsu_rmw_if.sv | 30 +++
 rtl/lsu_rmw.sv | 106 ++++++++++
 2 files changed

// File: rtl/lsu_rmw_if.sv
// Bus bundle between the MEM-stage pipeline, the LSU and the word-only data memory.
// The pipeline-side/memory-side agent uses the master modport; the LSU uses slave.
interface lsu_rmw_if #(
    parameter int DMEM = 12
);
    logic            req_valid_i;
    logic            req_we_i;
    logic [2:0]      funct3_i;
    logic [31:0]     addr_i;
    logic [31:0]     wdata_i;
    logic            stall_o;
    logic [31:0]     rdata_o;
    logic            misalign_o;
    logic [DMEM-1:0] dmem_addr_o;
    logic [31:0]     dmem_wdata_o;
    logic            dmem_wren_o;
    logic [31:0]     dmem_rdata_i;

    modport master (
        output req_valid_i, req_we_i, funct3_i, addr_i, wdata_i, dmem_rdata_i,
        input  stall_o, rdata_o, misalign_o, dmem_addr_o, dmem_wdata_o,
        input  dmem_wren_o
    );

    modport slave (
        input  req_valid_i, req_we_i, funct3_i, addr_i, wdata_i, dmem_rdata_i,
        output stall_o, rdata_o, misalign_o, dmem_addr_o, dmem_wdata_o,
        output dmem_wren_o
    );
endinterface

// File: rtl/lsu_rmw.sv
// Load/store unit: RV32I load extension and SB/SH read-modify-write on a word memory.
// Optional misaligned-access flagging is enabled by defining LSU_MISALIGN_TRAP_EN.
module lsu_rmw #(
    parameter int DMEM = 12
) (
    input  logic      clk_i,
    input  logic      rst_ni,
    lsu_rmw_if.slave  bus
);
    typedef enum logic {IDLE, WRITE} state_t;

    state_t      state, state_next;
    logic [31:0] mbuf, mbuf_next;
    logic [1:0]  off;
    logic        hoff;
    logic        mis;
    logic        is_load, is_store;
    logic        sub_store, word_store;
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;
    logic [31:0] load_data;
    logic        unused_addr;

    assign off = bus.addr_i[1:0];
    assign hoff = off[1];
    assign unused_addr = ^bus.addr_i[31:DMEM];

    assign is_load  = (state == IDLE) && bus.req_valid_i && !bus.req_we_i;
    assign is_store = (state == IDLE) && bus.req_valid_i && bus.req_we_i;

`ifdef LSU_MISALIGN_TRAP_EN
    always_comb begin
        mis = 1'b0;
        if (is_load) begin
            case (bus.funct3_i)
                3'b001, 3'b101: mis = off[0];
                3'b010:         mis = (off != 2'b00);
                default:        mis = 1'b0;
            endcase
        end else if (is_store) begin
            case (bus.funct3_i)
                3'b001:  mis = off[0];
                3'b010:  mis = (off != 2'b00);
                default: mis = 1'b0;
            endcase
        end
    end
`else
    assign mis = 1'b0;
`endif

    assign sub_store  = is_store && !mis &&
                        (bus.funct3_i == 3'b000 || bus.funct3_i == 3'b001);
    assign word_store = is_store && !mis && (bus.funct3_i == 3'b010);

    assign sel_byte = bus.dmem_rdata_i[{off, 3'b000} +: 8];
    assign sel_half = bus.dmem_rdata_i[{hoff, 4'b0000} +: 16];

    always_comb begin
        load_data = 32'h0;
        case (bus.funct3_i)
            3'b000:  load_data = {{24{sel_byte[7]}}, sel_byte};
            3'b100:  load_data = {24'h0, sel_byte};
            3'b001:  load_data = {{16{sel_half[15]}}, sel_half};
            3'b101:  load_data = {16'h0, sel_half};
            3'b010:  load_data = bus.dmem_rdata_i;
            default: load_data = 32'h0;
        endcase
    end

    // Merge the new byte/half into the word currently read from memory
    always_comb begin
        mbuf_next = bus.dmem_rdata_i;
        if (bus.funct3_i == 3'b000)
            mbuf_next[{off, 3'b000} +: 8] = bus.wdata_i[7:0];
        else
            mbuf_next[{hoff, 4'b0000} +: 16] = bus.wdata_i[15:0];
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (sub_store) state_next = WRITE;
            WRITE:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state <= IDLE;
            mbuf  <= 32'h0;
        end else begin
            state <= state_next;
            if (sub_store)
                mbuf <= mbuf_next;
        end
    end

    assign bus.dmem_addr_o  = {bus.addr_i[DMEM-1:2], 2'b00};
    assign bus.dmem_wdata_o = (state == WRITE) ? mbuf : bus.wdata_i;
    assign bus.dmem_wren_o  = rst_ni && ((state == WRITE) || word_store);
    assign bus.stall_o      = rst_ni && sub_store;
    assign bus.misalign_o   = rst_ni && mis;
    assign bus.rdata_o      = (rst_ni && is_load && !mis) ? load_data : 32'h0;
endmodule
